// File: rtl/mem_pkg.sv
// Shared types for the parametrised burst memory: access sizes, FSM states, beat counts.
// Pure declarations, no logic and no latency.
// No flow control here; the controller owns busy/abort handling.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_1  = 2'd0,
        SZ_4  = 2'd1,
        SZ_8  = 2'd2,
        SZ_16 = 2'd3
    } access_size_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    function automatic logic [4:0] beats(access_size_e sz);
        case (sz)
            SZ_1:    beats = 5'd1;
            SZ_4:    beats = 5'd4;
            SZ_8:    beats = 5'd8;
            default: beats = 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/mem_sram_array.sv
// Single-port synchronous word array with write enable and registered read port.
// Latency: read data appears one clk after rd_en; writes land on the same edge.
// No backpressure; the caller never asserts rd_en and wr_en together.
module mem_sram_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 262144,
    parameter int IDX_W       = 18
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wr_dat,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Contents and read register are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[idx];
        end
    end

endmodule

// File: rtl/memory_burst_param.sv
// Burst memory controller: single/4/8/16-beat read/write bursts with range and alignment checks.
// Latency: each beat executes on the accepting edge; read data and addr_err are valid the following cycle.
// Backpressure: busy is high while a burst is pending; dropping enable mid-burst aborts it.
module memory_burst_param
    import mem_pkg::*;
#(
    parameter int        DATA_W      = 32,
    parameter int        DEPTH_WORDS = 262144,
    parameter bit [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int        ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              read_write,
    input  logic [1:0]        access_size,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              addr_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    // One spare MSB so a burst running past the top of the address space
    // stays out of range instead of wrapping back into the array.
    localparam logic [ADDR_W:0] BASE_EXT = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] SPAN     = (ADDR_W+1)'(longint'(DEPTH_WORDS) * longint'(BYTES));
    localparam logic [ADDR_W:0] STEP     = (ADDR_W+1)'(BYTES);
    localparam logic [ADDR_W:0] OFF_MASK = (ADDR_W+1)'(BYTES - 1);

    state_e            state_q, state_d;
    logic [4:0]        rem_q, rem_d;
    logic              rw_q, rw_d;
    logic [ADDR_W:0]   cur_addr_q, cur_addr_d;
    logic              data_valid_q;
    logic              addr_err_q;
    logic              rd_zero_q;

    logic              beat_rw;
    logic [ADDR_W:0]   beat_addr;
    logic              in_range;
    logic              aligned;
    logic              beat_ok;
    logic              rd_beat;
    logic              wr_beat;
    logic [IDX_W-1:0]  beat_idx;
    logic [DATA_W-1:0] rd_dat;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        rw_d       = rw_q;
        cur_addr_d = cur_addr_q;
        beat_rw    = read_write;
        beat_addr  = {1'b0, address};
        case (state_q)
            IDLE: begin
                if (enable) begin
                    rw_d       = read_write;
                    cur_addr_d = beat_addr;
                    rem_d      = beats(access_size_e'(access_size)) - 5'd1;
                    if (beats(access_size_e'(access_size)) != 5'd1) begin
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                beat_rw   = rw_q;
                beat_addr = cur_addr_q + STEP;
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    cur_addr_d = beat_addr;
                    rem_d      = rem_q - 5'd1;
                    if (rem_q == 5'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A beat happens on every enabled edge: accept in IDLE, continue in BURST.
    assign in_range = (beat_addr >= BASE_EXT) && ((beat_addr - BASE_EXT) < SPAN);
    assign aligned  = ((beat_addr & OFF_MASK) == '0);
    assign beat_ok  = in_range && aligned;
    assign rd_beat  = enable && (beat_rw == RW_READ);
    assign wr_beat  = enable && (beat_rw == RW_WRITE);
    assign beat_idx = IDX_W'((beat_addr - BASE_EXT) >> OFF_W);

    mem_sram_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk    (clk),
        .wr_en  (wr_beat && beat_ok),
        .rd_en  (rd_beat && beat_ok),
        .idx    (beat_idx),
        .wr_dat (data_in),
        .rd_dat (rd_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            rw_q         <= RW_READ;
            cur_addr_q   <= '0;
            data_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            rd_zero_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            rw_q         <= rw_d;
            cur_addr_q   <= cur_addr_d;
            data_valid_q <= rd_beat;
            addr_err_q   <= enable && !beat_ok;
            // rd_zero_q masks the array output for bad reads and holds between reads.
            if (rd_beat) begin
                rd_zero_q <= !beat_ok;
            end
        end
    end

    assign data_out   = rd_zero_q ? '0 : rd_dat;
    assign data_valid = data_valid_q;
    assign addr_err   = addr_err_q;
    assign busy       = (state_q == BURST);

endmodule

// File: tb/tb_memory_burst_param.sv
// Testbench for memory_burst_param: table-driven beats plus hand-written abort and reset sequences.
// Each cycle's expectation is queued when driven and checked one edge later.
module tb_memory_burst_param;

    typedef struct {
        logic        en;
        logic        rw;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] din;
        logic        dv;
        logic [31:0] dout;
        logic        err;
        logic        busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        read_write = 1'b0;
    logic [1:0]  access_size = 2'd0;
    logic [31:0] address = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        data_valid;
    logic        busy;
    logic        addr_err;

    int n_vec = 0;
    int n_err = 0;
    vec_t sb[$];
    vec_t tbl[21];

    memory_burst_param dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .read_write  (read_write),
        .access_size (access_size),
        .address     (address),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .busy        (busy),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic en, input logic rw, input logic [1:0] sz,
                               input logic [31:0] addr, input logic [31:0] din,
                               input logic dv, input logic [31:0] dout,
                               input logic err, input logic bsy);
        vec_t r;
        r.en = en; r.rw = rw; r.sz = sz; r.addr = addr; r.din = din;
        r.dv = dv; r.dout = dout; r.err = err; r.busy = bsy;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input string tag, input vec_t x);
        vec_t e;
        @(negedge clk);
        enable      = x.en;
        read_write  = x.rw;
        access_size = x.sz;
        address     = x.addr;
        data_in     = x.din;
        sb.push_back(x);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_vec++;
        chk({tag, ".data_valid"}, {31'd0, data_valid}, {31'd0, e.dv});
        chk({tag, ".data_out"}, data_out, e.dout);
        chk({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, e.err});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e.busy});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single accesses, a 4-beat write/read, then the top-of-array boundary.
        tbl[0]  = v(1, 0, 0, 0,        234,         0, 0,           0, 0);
        tbl[1]  = v(1, 1, 0, 0,        0,           1, 234,         0, 0);
        tbl[2]  = v(1, 0, 1, 0,        234,         0, 234,         0, 1);
        tbl[3]  = v(1, 1, 0, 999,      1537628013,  0, 234,         0, 1);
        tbl[4]  = v(1, 1, 3, 5,        537628013,   0, 234,         0, 1);
        tbl[5]  = v(1, 1, 0, 0,        32'd2537628013, 0, 234,      0, 0);
        tbl[6]  = v(1, 1, 1, 0,        0,           1, 234,         0, 1);
        tbl[7]  = v(1, 0, 0, 8,        0,           1, 1537628013,  0, 1);
        tbl[8]  = v(1, 0, 0, 8,        0,           1, 537628013,   0, 1);
        tbl[9]  = v(1, 0, 0, 8,        0,           1, 32'd2537628013, 0, 0);
        tbl[10] = v(0, 0, 0, 0,        0,           0, 32'd2537628013, 0, 0);
        tbl[11] = v(1, 0, 0, 1048572,  10448573,    0, 32'd2537628013, 0, 0);
        tbl[12] = v(1, 1, 0, 1048572,  0,           1, 10448573,    0, 0);
        tbl[13] = v(1, 0, 0, 1048576,  910448573,   0, 10448573,    1, 0);
        tbl[14] = v(1, 1, 0, 1048576,  0,           1, 0,           1, 0);
        tbl[15] = v(1, 0, 0, 1048568,  77,          0, 0,           0, 0);
        tbl[16] = v(1, 1, 1, 1048568,  0,           1, 77,          0, 1);
        tbl[17] = v(1, 1, 1, 0,        0,           1, 10448573,    0, 1);
        tbl[18] = v(1, 1, 1, 0,        0,           1, 0,           1, 1);
        tbl[19] = v(1, 1, 1, 0,        0,           1, 0,           1, 0);
        tbl[20] = v(0, 0, 0, 0,        0,           0, 0,           0, 0);

        #12;
        n_vec++;
        chk("reset.data_out", data_out, 32'd0);
        chk("reset.data_valid", {31'd0, data_valid}, 32'd0);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.addr_err", {31'd0, addr_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            step($sformatf("tbl%0d", i), tbl[i]);
        end

        // Prefill 80..92, then abort an 8-beat write at 64 after four beats.
        step("pre0", v(1, 0, 1, 80, 32'hA0, 0, 0, 0, 1));
        step("pre1", v(1, 0, 0, 0,  32'hA4, 0, 0, 0, 1));
        step("pre2", v(1, 0, 0, 0,  32'hA8, 0, 0, 0, 1));
        step("pre3", v(1, 0, 0, 0,  32'hAC, 0, 0, 0, 0));
        step("abw0", v(1, 0, 2, 64, 32'h40, 0, 0, 0, 1));
        step("abw1", v(1, 0, 0, 0,  32'h44, 0, 0, 0, 1));
        step("abw2", v(1, 0, 0, 0,  32'h48, 0, 0, 0, 1));
        step("abw3", v(1, 0, 0, 0,  32'h4C, 0, 0, 0, 1));
        step("abort", v(0, 0, 0, 0, 32'h50, 0, 0, 0, 0));
        step("post_rd", v(1, 1, 0, 64, 0, 1, 32'h40, 0, 0));
        step("rd64_0", v(1, 1, 1, 64, 0, 1, 32'h40, 0, 1));
        step("rd64_1", v(1, 1, 0, 0,  0, 1, 32'h44, 0, 1));
        step("rd64_2", v(1, 1, 0, 0,  0, 1, 32'h48, 0, 1));
        step("rd64_3", v(1, 1, 0, 0,  0, 1, 32'h4C, 0, 0));
        step("rd80_0", v(1, 1, 1, 80, 0, 1, 32'hA0, 0, 1));
        step("rd80_1", v(1, 1, 0, 0,  0, 1, 32'hA4, 0, 1));
        step("rd80_2", v(1, 1, 0, 0,  0, 1, 32'hA8, 0, 1));
        step("rd80_3", v(1, 1, 0, 0,  0, 1, 32'hAC, 0, 0));

        // Asynchronous reset in the middle of a 16-beat read.
        step("rd16_0", v(1, 1, 3, 0, 0, 1, 234, 0, 1));
        step("rd16_1", v(1, 1, 0, 0, 0, 1, 1537628013, 0, 1));
        #2;
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        n_vec++;
        chk("midrst.data_out", data_out, 32'd0);
        chk("midrst.data_valid", {31'd0, data_valid}, 32'd0);
        chk("midrst.busy", {31'd0, busy}, 32'd0);
        chk("midrst.addr_err", {31'd0, addr_err}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step("after_rst", v(1, 1, 0, 4, 0, 1, 1537628013, 0, 0));
        step("misalign", v(1, 1, 0, 2, 0, 1, 0, 1, 0));
        step("idle_end", v(0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/memory_burst_param.md
Name: memory_burst_param

Overview:
Parametrised successor to the single-port 32-bit main memory used by the MIPS core and its loader.
- Configurable data width, depth and base address.
- Adds true multi-beat bursts (1/4/8/16 words), explicit read-data valid, address-error reporting, and mid-burst abort.
- Sits between the fetch/LSU stages and the backing store.
- Single clock domain; one access (single or burst) in flight at a time.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8.
DEPTH_WORDS, 262144, number of words (default 1 MiB).
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned.
ADDR_W, 32, byte address width.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
enable  in  1  request strobe; sampled on rising clk.
read_write  in  1  1 = read, 0 = write.
access_size  in  2  0 = 1 beat, 1 = 4 beats, 2 = 8 beats, 3 = 16 beats.
address  in  ADDR_W  byte address of the first beat.
data_in  in  DATA_W  write data for the current beat.
data_out  out  DATA_W  read data, registered.
data_valid  out  1  data_out holds a read beat from the previous edge.
busy  out  1  burst in progress; new requests are not accepted.
addr_err  out  1  current beat is out of range or misaligned.

Behaviour:
- Reset: async on rst_n low. Outputs data_out=0, data_valid=0, busy=0, addr_err=0; state=IDLE. Array contents are not reset.
- States:
  - IDLE: accepts requests.
  - BURST: remaining beats pending.
- Beat address decode:
  - Word index = (addr - BASE_ADDR) >> log2(DATA_W/8).
  - A beat is in range iff BASE_ADDR <= addr < BASE_ADDR + DEPTH_WORDS*(DATA_W/8).
  - A beat is aligned iff the low byte-offset bits are 0.
- IDLE, posedge with enable=1:
  - Latch read_write, address and beat count.
  - Perform beat 0 on the same edge: write stores data_in; read loads data_out.
  - If access_size=0, stay IDLE with busy=0. Otherwise go to BURST with remaining = beats-1 and busy=1.
- BURST, posedge with enable=1:
  - Address += DATA_W/8; perform the next beat; remaining decrements.
  - Write beats sample data_in at that edge.
  - When the last beat completes: return to IDLE, busy=0.
  - read_write, access_size and address inputs are ignored during BURST.
- BURST, posedge with enable=0: abort. No beat is performed; go to IDLE; busy=0; data_valid=0.
- Read latency: 1 cycle. data_valid=1 for exactly the cycle after each read beat edge; otherwise 0.
- data_out holds its last value when no read beat occurs.
- Bad beat (out of range or misaligned):
  - Write is suppressed; read returns data_out=0 with data_valid=1.
  - addr_err=1 for that cycle.
  - The burst continues; there is no wrap-around and addresses beyond the end stay erroneous.
- busy timeline for an N-beat burst: 0 after the accept edge if N=1; else 1 for N-1 cycles.
- A request issued on the edge busy falls (IDLE again) is accepted.
- Reset mid-burst: immediate return to IDLE; the partially written burst stays in the array.

Decomposition:
- Package mem_pkg:
  - access_size_e enum (SZ_1, SZ_4, SZ_8, SZ_16).
  - state_e enum (IDLE, BURST).
  - Function beats(access_size_e) returning 1/4/8/16.
  - RW_READ=1'b1 and RW_WRITE=1'b0 constants.
- Sub-module mem_sram_array: single-port synchronous array (DATA_W x DEPTH_WORDS) with write enable and registered read. The controller FSM, address generator and range check stay in the top level.

Test Plan:
1. Reset, then single write 234 to address 0, then single read of address 0 -> data_out=234, data_valid=1 one cycle after the read edge; busy stays 0.
2. 4-beat write at address 0 with data 234, 1537628013, 537628013, 2537628013 on consecutive edges, then 4-beat read at 0 -> same four values on four consecutive cycles; busy=1 for 3 cycles each burst.
3. Single write 10448573 to address 1048572, then read it back -> 10448573, addr_err=0. Write 910448573 to address 1048576 -> addr_err=1; a subsequent read of 1048576 gives data_out=0, addr_err=1.
4. 4-beat read at 1048568 -> beats 0-1 return stored data; beats 2-3 return 0 with addr_err=1.
5. 8-beat write at address 64 with enable dropped after beat 3 -> busy falls; words 64..76 are written, 80..92 are unchanged. A new single read on the next edge is accepted.
6. rst_n pulsed low during a 16-beat read -> all outputs 0 asynchronously; after release, a single read of address 4 is accepted normally. A misaligned read of address 2 -> addr_err=1.
